pu_seq_ctrl: RTL

- Sequencer for one processing unit (MAC cluster + weight memory + result memory).
- Accepts a layer job (pass count, output count, base addresses, bias/relu flags) and steps the MAC cluster through every partial-sum beat.
- Handshakes input data beats with an upstream feeder and schedules result-memory writes once final sums emerge.
- Sits between the top-level layer scheduler and a single PU instance.

---
 rtl/pu_seq_ctrl_if.sv | 25 ++
 rtl/pu_seq_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// pu_seq_ctrl_if : feeder-to-sequencer data beat handshake (valid/ready/data)
// Rev 1.0 - initial release
// ============================================================================
interface pu_seq_ctrl_if #(
  parameter int TOTAL_INPUT_WIDTH = 512
) ();
  logic                         in_data_valid;
  logic [TOTAL_INPUT_WIDTH-1:0] in_data;
  logic                         out_data_ready;

  modport master (
    output in_data_valid,
    output in_data,
    input  out_data_ready
  );

  modport slave (
    input  in_data_valid,
    input  in_data,
    output out_data_ready
  );
endinterface
`default_nettype wire

// File: rtl/pu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// pu_seq_ctrl : steps one PU's MAC cluster through every partial-sum beat of a
//               layer job and schedules the result-memory writes.
// Rev 1.0 - initial release
// ============================================================================
module pu_seq_ctrl #(
  parameter int DATA_WIDTH        = 8,
  parameter int NUM_MAC4          = 16,
  parameter int TOTAL_INPUT_WIDTH = NUM_MAC4*4*DATA_WIDTH,
  parameter int WADDR_WIDTH       = 7,
  parameter int MAC_LAT           = 2
) (
  input  wire logic                         clk,
  input  wire logic                         rst_n,
  input  wire logic                         in_start,
  input  wire logic [4:0]                   in_cfg_passes_m1,
  input  wire logic [4:0]                   in_cfg_outputs_m1,
  input  wire logic [WADDR_WIDTH-1:0]       in_cfg_w_base,
  input  wire logic [WADDR_WIDTH-1:0]       in_cfg_r_base,
  input  wire logic                         in_cfg_bias,
  input  wire logic                         in_cfg_relu,
  pu_seq_ctrl_if.slave                      feed,
  output logic [WADDR_WIDTH-1:0]            out_w_rd_addr,
  output logic                              out_mac_en,
  output logic [TOTAL_INPUT_WIDTH-1:0]      out_mac_data,
  output logic                              out_add_bias,
  output logic                              out_relu,
  output logic                              out_done,
  output logic                              out_cache_clear,
  output logic                              out_cache_wr_en,
  output logic [4:0]                        out_cache_rd_addr,
  output logic [4:0]                        out_cache_wr_addr,
  output logic [2:0]                        out_bias_addr,
  output logic                              out_r_wr_en,
  output logic [WADDR_WIDTH-1:0]            out_r_wr_addr,
  output logic                              out_busy,
  output logic                              out_finish
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(MAC_LAT);

  state_t                  state, state_nxt;
  logic [4:0]              cfg_passes_m1, cfg_outputs_m1;
  logic [WADDR_WIDTH-1:0]  cfg_r_base;
  logic                    cfg_bias, cfg_relu;
  logic [4:0]              p, o;
  logic [WADDR_WIDTH-1:0]  wp;
  logic [2:0]              drain_cnt;
  logic [WADDR_WIDTH-1:0]  res_addr;
  logic [MAC_LAT-1:0]      dl_vld;
  logic [WADDR_WIDTH-1:0]  dl_addr [MAC_LAT];

  logic start_ok, beat, last_pass, last_out;

  // The finish cycle still counts as busy, so a start landing on it is ignored.
  assign start_ok  = (state == S_IDLE) && in_start && !out_finish;
  assign beat      = (state == S_RUN) && feed.in_data_valid;
  assign last_pass = (p == cfg_passes_m1);
  assign last_out  = (o == cfg_outputs_m1);

  assign feed.out_data_ready = (state == S_RUN);
  assign out_w_rd_addr       = wp;
  assign out_busy            = (state != S_IDLE) || out_finish;
  assign out_r_wr_en         = dl_vld[MAC_LAT-1];
  assign out_r_wr_addr       = dl_addr[MAC_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_RUN;
      S_RUN:   if (beat && last_pass && last_out) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_passes_m1   <= '0;
      cfg_outputs_m1  <= '0;
      cfg_r_base      <= '0;
      cfg_bias        <= 1'b0;
      cfg_relu        <= 1'b0;
      p               <= '0;
      o               <= '0;
      wp              <= '0;
      drain_cnt       <= '0;
      out_finish      <= 1'b0;
      out_cache_clear <= 1'b0;
    end else begin
      if (start_ok) begin
        cfg_passes_m1  <= in_cfg_passes_m1;
        cfg_outputs_m1 <= in_cfg_outputs_m1;
        cfg_r_base     <= in_cfg_r_base;
        cfg_bias       <= in_cfg_bias;
        cfg_relu       <= in_cfg_relu;
        p              <= '0;
        o              <= '0;
        wp             <= in_cfg_w_base;
      end else if (beat) begin
        wp <= wp + 1'b1;
        if (last_out) begin
          o <= '0;
          p <= p + 5'd1;
        end else begin
          o <= o + 5'd1;
        end
      end
      drain_cnt       <= (state == S_DRAIN) ? drain_cnt + 3'd1 : 3'd0;
      out_finish      <= (state == S_DRAIN) && (drain_cnt == DRAIN_LAST);
      out_cache_clear <= (state == S_CLEAR);
    end
  end

  // Beat strobes lag the beat by one cycle to line up with the weight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_mac_en        <= 1'b0;
      out_done          <= 1'b0;
      out_cache_wr_en   <= 1'b0;
      out_add_bias      <= 1'b0;
      out_relu          <= 1'b0;
      out_mac_data      <= '0;
      out_cache_rd_addr <= '0;
      out_cache_wr_addr <= '0;
      out_bias_addr     <= '0;
      res_addr          <= '0;
    end else begin
      out_mac_en      <= beat;
      out_done        <= beat && last_pass;
      out_cache_wr_en <= beat && !last_pass;
      out_add_bias    <= beat && last_pass && cfg_bias;
      out_relu        <= beat && last_pass && cfg_relu;
      if (beat) begin
        out_mac_data      <= feed.in_data;
        out_cache_rd_addr <= o;
        out_cache_wr_addr <= o;
        out_bias_addr     <= o[2:0];
        res_addr          <= cfg_r_base + WADDR_WIDTH'(o);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld <= '0;
      for (int i = 0; i < MAC_LAT; i++) dl_addr[i] <= '0;
    end else begin
      dl_vld[0]  <= out_done;
      dl_addr[0] <= res_addr;
      for (int i = 1; i < MAC_LAT; i++) begin
        dl_vld[i]  <= dl_vld[i-1];
        dl_addr[i] <= dl_addr[i-1];
      end
    end
  end

endmodule
`default_nettype wire
